vector_store_mcu: RTL

- Store-side memory control unit; the consumer end of the lanes' store-data interface.
- Accepts store commands from the scheduler (mcu_st_vld/mcu_st_rdy handshake).
- Pulls element beats from the vector lanes and serializes them into single-element memory write transactions with byte strobes.
- Supports unit-stride and strided stores; indexed stores are outside this block's scope.

---
 rtl/vector_store_pkg.sv | 51 +++++
 rtl/store_elem_formatter.sv | 15 +
 rtl/vector_store_mcu.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vector_store_pkg.sv
// Shared types and element-format helpers for the vector store memory control unit.
package vector_store_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BEAT,
    S_ISSUE,
    S_DONE
  } st_state_e;

  localparam logic [2:0] W8  = 3'b000;
  localparam logic [2:0] W16 = 3'b101;
  localparam logic [2:0] W32 = 3'b110;

  // Bytes per element; any unrecognised width code behaves as 32b.
  function automatic logic [31:0] elem_bytes(input logic [2:0] width);
    case (width)
      W8:      elem_bytes = 32'd1;
      W16:     elem_bytes = 32'd2;
      default: elem_bytes = 32'd4;
    endcase
  endfunction

  // Forces natural alignment of an element byte address.
  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [2:0] width);
    case (width)
      W8:      align_addr = addr;
      W16:     align_addr = {addr[31:1], 1'b0};
      default: align_addr = {addr[31:2], 2'b00};
    endcase
  endfunction

  // Byte enables for an element at the given word offset.
  function automatic logic [3:0] elem_strb(input logic [2:0] width, input logic [1:0] addr_lo);
    case (width)
      W8:      elem_strb = 4'b0001 << addr_lo;
      W16:     elem_strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: elem_strb = 4'hF;
    endcase
  endfunction

  // Replicates the element across the word so any strobe position sees it.
  function automatic logic [31:0] elem_data(input logic [2:0] width, input logic [31:0] sew_data);
    case (width)
      W8:      elem_data = {4{sew_data[7:0]}};
      W16:     elem_data = {2{sew_data[15:0]}};
      default: elem_data = sew_data;
    endcase
  endfunction

endpackage

// File: rtl/store_elem_formatter.sv
// Combinational lane-alignment of one element into a 32-bit write word and strobe.
module store_elem_formatter
  import vector_store_pkg::*;
(
  input  logic [31:0] sew_data,
  input  logic [2:0]  width,
  input  logic [1:0]  addr_lo,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  assign wdata = elem_data(width, sew_data);
  assign wstrb = elem_strb(width, addr_lo);

endmodule

// File: rtl/vector_store_mcu.sv
// Store-side memory control unit: pulls lane beats and serialises them into
// single-element memory writes (unit-stride or strided).
module vector_store_mcu
  import vector_store_pkg::*;
#(
  parameter int VLANE_NUM = 16,
  parameter int MEM_WIDTH = 32,
  parameter int VL_WIDTH  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           mcu_st_vld_i,
  output logic                           mcu_st_rdy_o,
  input  logic [31:0]                    mcu_base_addr_i,
  input  logic [31:0]                    mcu_stride_i,
  input  logic [2:0]                     mcu_data_width_i,
  input  logic                           mcu_unit_ld_st_i,
  input  logic                           mcu_strided_ld_st_i,
  input  logic [VL_WIDTH-1:0]            vl_i,
  input  logic [VLANE_NUM*MEM_WIDTH-1:0] store_data_i,
  input  logic                           store_data_valid_i,
  output logic                           ready_for_store_o,
  output logic                           mem_wvalid_o,
  input  logic                           mem_wready_i,
  output logic [31:0]                    mem_waddr_o,
  output logic [MEM_WIDTH-1:0]           mem_wdata_o,
  output logic [3:0]                     mem_wstrb_o,
  output logic                           st_done_o
);

  localparam int LANE_W = (VLANE_NUM > 1) ? $clog2(VLANE_NUM) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VLANE_NUM - 1);

  st_state_e             state_reg, state_next;
  logic [MEM_WIDTH-1:0]  lane_data [VLANE_NUM];
  logic [MEM_WIDTH-1:0]  beat_reg  [VLANE_NUM];
  logic [31:0]           addr_reg, step_reg;
  logic [2:0]            width_reg;
  logic [VL_WIDTH-1:0]   vl_reg, elem_idx_reg;
  logic [LANE_W-1:0]     lane_idx_reg, lane_next;
  logic [31:0]           waddr_reg;
  logic [MEM_WIDTH-1:0]  wdata_reg, fmt_wdata, fmt_sew;
  logic [3:0]            wstrb_reg, fmt_wstrb;
  logic [31:0]           addr_adv, fmt_addr, fmt_aligned;
  logic                  accept, capture, handshake, last_elem, last_lane;

  genvar gi;
  generate
    for (gi = 0; gi < VLANE_NUM; gi++) begin : g_lane
      assign lane_data[gi] = store_data_i[gi*MEM_WIDTH +: MEM_WIDTH];
      // Beat buffer for this lane; discarded on reset.
      always_ff @(posedge clk_i) begin
        if (rst_i) beat_reg[gi] <= '0;
        else if (capture) beat_reg[gi] <= lane_data[gi];
      end
    end
  endgenerate

  assign accept    = (state_reg == S_IDLE) && mcu_st_vld_i;
  assign capture   = (state_reg == S_WAIT_BEAT) && store_data_valid_i;
  assign handshake = (state_reg == S_ISSUE) && mem_wready_i;
  assign last_elem = (elem_idx_reg + 1'b1) == vl_reg;
  assign last_lane = lane_idx_reg == LAST_LANE;
  assign lane_next = lane_idx_reg + 1'b1;
  assign addr_adv  = addr_reg + step_reg;

  // Next element to present: lane 0 of a fresh beat, or the following buffered lane.
  assign fmt_sew     = capture ? lane_data[0] : beat_reg[lane_next];
  assign fmt_addr    = capture ? addr_reg : addr_adv;
  assign fmt_aligned = align_addr(fmt_addr, width_reg);

  store_elem_formatter u_fmt (
    .sew_data (fmt_sew),
    .width    (width_reg),
    .addr_lo  (fmt_aligned[1:0]),
    .wdata    (fmt_wdata),
    .wstrb    (fmt_wstrb)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and handshake output decode.
  always_comb begin
    state_next        = state_reg;
    mcu_st_rdy_o      = 1'b0;
    ready_for_store_o = 1'b0;
    mem_wvalid_o      = 1'b0;
    st_done_o         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        mcu_st_rdy_o = 1'b1;
        if (mcu_st_vld_i) state_next = (vl_i == '0) ? S_DONE : S_WAIT_BEAT;
      end
      S_WAIT_BEAT: begin
        ready_for_store_o = 1'b1;
        if (store_data_valid_i) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_wvalid_o = 1'b1;
        if (mem_wready_i) begin
          if (last_elem)      state_next = S_DONE;
          else if (last_lane) state_next = S_WAIT_BEAT;
        end
      end
      S_DONE: begin
        st_done_o  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command latch, element/lane counters, address accumulator and registered write outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_reg     <= '0;
      step_reg     <= '0;
      width_reg    <= '0;
      vl_reg       <= '0;
      elem_idx_reg <= '0;
      lane_idx_reg <= '0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
    end else begin
      if (accept) begin
        addr_reg     <= mcu_base_addr_i;
        width_reg    <= mcu_data_width_i;
        step_reg     <= (mcu_unit_ld_st_i || !mcu_strided_ld_st_i)
                        ? elem_bytes(mcu_data_width_i) : mcu_stride_i;
        vl_reg       <= vl_i;
        elem_idx_reg <= '0;
        lane_idx_reg <= '0;
      end
      if (capture) begin
        lane_idx_reg <= '0;
        waddr_reg    <= {fmt_aligned[31:2], 2'b00};
        wdata_reg    <= fmt_wdata;
        wstrb_reg    <= fmt_wstrb;
      end
      if (handshake) begin
        elem_idx_reg <= elem_idx_reg + 1'b1;
        lane_idx_reg <= lane_next;
        addr_reg     <= addr_adv;
        // Only reload the outputs when another element of this beat follows.
        if (!last_elem && !last_lane) begin
          waddr_reg <= {fmt_aligned[31:2], 2'b00};
          wdata_reg <= fmt_wdata;
          wstrb_reg <= fmt_wstrb;
        end
      end
    end
  end

  assign mem_waddr_o = waddr_reg;
  assign mem_wdata_o = wdata_reg;
  assign mem_wstrb_o = wstrb_reg;

endmodule
